// File: rtl/ibex_mem_arb.sv
// N-to-1 round-robin arbiter for the Ibex req/gnt/rvalid memory protocol, with an in-order tag FIFO that routes responses.
// Optional stall counter enabled by defining IBEX_MEM_ARB_PERF_EN.
module ibex_mem_arb #(
    parameter int NUM_HOSTS       = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int INTG_WIDTH      = 7,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_HOSTS-1:0]             host_req_i,
    output logic [NUM_HOSTS-1:0]             host_gnt_o,
    input  logic [NUM_HOSTS*ADDR_WIDTH-1:0]  host_addr_i,
    input  logic [NUM_HOSTS-1:0]             host_we_i,
    input  logic [NUM_HOSTS*DATA_WIDTH/8-1:0] host_be_i,
    input  logic [NUM_HOSTS*DATA_WIDTH-1:0]  host_wdata_i,
    input  logic [NUM_HOSTS*INTG_WIDTH-1:0]  host_wintg_i,
    output logic [NUM_HOSTS-1:0]             host_rvalid_o,
    output logic [DATA_WIDTH-1:0]            host_rdata_o,
    output logic [INTG_WIDTH-1:0]            host_rintg_o,
    output logic                             host_err_o,
    output logic                             dev_req_o,
    output logic [ADDR_WIDTH-1:0]            dev_addr_o,
    output logic                             dev_we_o,
    output logic [DATA_WIDTH/8-1:0]          dev_be_o,
    output logic [DATA_WIDTH-1:0]            dev_wdata_o,
    output logic [INTG_WIDTH-1:0]            dev_wintg_o,
    input  logic                             dev_gnt_i,
    input  logic                             dev_rvalid_i,
    input  logic [DATA_WIDTH-1:0]            dev_rdata_i,
    input  logic [INTG_WIDTH-1:0]            dev_rintg_i,
    input  logic                             dev_err_i,
    output logic                             orphan_rsp_o,
    output logic [31:0]                      arb_stall_cnt_o
);

    localparam int IDX_W = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             lock_valid_q, lock_valid_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             orphan_q, orphan_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];

    logic [IDX_W-1:0] rr_idx, sel_idx, head_idx;
    logic             rr_found, fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head_idx   = fifo_q[rd_ptr_q];

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rr_idx   = last_grant_q;
        rr_found = 1'b0;
        // First hosts above last_grant, then wrap to the bottom.
        for (int i = 0; i < NUM_HOSTS; i++) begin
            if (!rr_found && i > int'(last_grant_q) && host_req_i[i]) begin
                rr_idx   = IDX_W'(i);
                rr_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_HOSTS; i++) begin
            if (!rr_found && host_req_i[i]) begin
                rr_idx   = IDX_W'(i);
                rr_found = 1'b1;
            end
        end
    end

    assign sel_idx   = lock_valid_q ? lock_idx_q : rr_idx;
    assign dev_req_o = (|host_req_i) && !fifo_full;
    assign push      = dev_req_o && dev_gnt_i;
    assign pop       = dev_rvalid_i && !fifo_empty;

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        dev_addr_o    = '0;
        dev_we_o      = 1'b0;
        dev_be_o      = '0;
        dev_wdata_o   = '0;
        dev_wintg_o   = '0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            if (dev_req_o && int'(sel_idx) == i) begin
                dev_addr_o    = host_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                dev_we_o      = host_we_i[i];
                dev_be_o      = host_be_i[i*BE_W +: BE_W];
                dev_wdata_o   = host_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                dev_wintg_o   = host_wintg_i[i*INTG_WIDTH +: INTG_WIDTH];
                host_gnt_o[i] = dev_gnt_i;
            end
            if (pop && int'(head_idx) == i) begin
                host_rvalid_o[i] = 1'b1;
            end
        end
    end

    assign host_rdata_o = dev_rdata_i;
    assign host_rintg_o = dev_rintg_i;
    assign host_err_o   = dev_err_i;
    assign orphan_rsp_o = orphan_q;

    always_comb begin
        last_grant_d = last_grant_q;
        lock_valid_d = lock_valid_q;
        lock_idx_d   = lock_idx_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        orphan_d     = orphan_q | (dev_rvalid_i && fifo_empty);
        if (push) begin
            last_grant_d = sel_idx;
            lock_valid_d = 1'b0;
            wr_ptr_d     = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else if (dev_req_o) begin
            // Freeze the choice until the device takes it.
            lock_valid_d = 1'b1;
            lock_idx_d   = sel_idx;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= IDX_W'(NUM_HOSTS - 1);
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            orphan_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_valid_q <= lock_valid_d;
            lock_idx_q   <= lock_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            orphan_q     <= orphan_d;
        end
    end

    // NOTE: tag storage has no reset; an entry is only read after it was written, guarded by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sel_idx;
        end
    end

`ifdef IBEX_MEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|host_req_i) && !(|host_gnt_o) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign arb_stall_cnt_o = stall_cnt_q;
`else
    assign arb_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_mem_arb.sv
// Scoreboard bench for ibex_mem_arb: expected routed responses are queued at grant time and checked on rvalid.
module tb_ibex_mem_arb;

    localparam int NH = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 7;

    typedef struct {
        int          host;
        logic [31:0] data;
    } rsp_t;

    logic               clk;
    logic               rst_n;
    logic [NH-1:0]      host_req;
    logic [NH-1:0]      host_gnt;
    logic [NH*AW-1:0]   host_addr;
    logic [NH-1:0]      host_we;
    logic [NH*DW/8-1:0] host_be;
    logic [NH*DW-1:0]   host_wdata;
    logic [NH*IW-1:0]   host_wintg;
    logic [NH-1:0]      host_rvalid;
    logic [DW-1:0]      host_rdata;
    logic [IW-1:0]      host_rintg;
    logic               host_err;
    logic               dev_req;
    logic [AW-1:0]      dev_addr;
    logic               dev_we;
    logic [DW/8-1:0]    dev_be;
    logic [DW-1:0]      dev_wdata;
    logic [IW-1:0]      dev_wintg;
    logic               dev_gnt;
    logic               dev_rvalid;
    logic [DW-1:0]      dev_rdata;
    logic [IW-1:0]      dev_rintg;
    logic               dev_err;
    logic               orphan_rsp;
    logic [31:0]        arb_stall_cnt;

    int   n_cmp;
    int   n_bad;
    rsp_t sb_q[$];

    ibex_mem_arb #(
        .NUM_HOSTS(NH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .INTG_WIDTH(IW), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_wintg_i(host_wintg), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
        .host_rintg_o(host_rintg), .host_err_o(host_err),
        .dev_req_o(dev_req), .dev_addr_o(dev_addr), .dev_we_o(dev_we), .dev_be_o(dev_be),
        .dev_wdata_o(dev_wdata), .dev_wintg_o(dev_wintg), .dev_gnt_i(dev_gnt),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_rintg_i(dev_rintg),
        .dev_err_i(dev_err), .orphan_rsp_o(orphan_rsp), .arb_stall_cnt_o(arb_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_host(input int i, input logic req, input logic [31:0] addr,
                            input logic we, input logic [31:0] wdata);
        host_req[i]             = req;
        host_addr[i*AW +: AW]   = addr;
        host_we[i]              = we;
        host_be[i*4 +: 4]       = 4'hF;
        host_wdata[i*DW +: DW]  = wdata;
        host_wintg[i*IW +: IW]  = wdata[6:0];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next();
        next();
        rst_n = 1'b1;
    endtask

    // Device returns the oldest expected response; the owning host must see rvalid.
    task automatic respond(input string tag, input bit chk_full);
        rsp_t e;
        check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            e          = sb_q.pop_front();
            dev_rvalid = 1'b1;
            dev_rdata  = e.data;
            dev_rintg  = e.data[6:0];
            dev_err    = e.data[0];
            @(negedge clk);
            check({tag, "_rvalid"}, 64'(host_rvalid), 64'(1 << e.host));
            check({tag, "_rdata"}, 64'(host_rdata), 64'(e.data));
            check({tag, "_rintg"}, 64'(host_rintg), 64'(e.data[6:0]));
            check({tag, "_err"}, 64'(host_err), 64'(e.data[0]));
            if (chk_full) begin
                check({tag, "_full_req"}, 64'(dev_req), 64'd0);
                check({tag, "_full_addr"}, 64'(dev_addr), 64'd0);
            end
            next();
            dev_rvalid = 1'b0;
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        host_req   = '0;
        host_addr  = '0;
        host_we    = '0;
        host_be    = '0;
        host_wdata = '0;
        host_wintg = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        dev_rintg  = '0;
        dev_err    = 1'b0;
        rst_n      = 1'b1;
        #2;
        do_reset();

        // Reset state with idle inputs
        @(negedge clk);
        check("rst_dev_req", 64'(dev_req), 64'd0);
        check("rst_gnt", 64'(host_gnt), 64'd0);
        check("rst_rvalid", 64'(host_rvalid), 64'd0);
        check("rst_orphan", 64'(orphan_rsp), 64'd0);
        check("rst_stall", 64'(arb_stall_cnt), 64'd0);
        check("rst_addr", 64'(dev_addr), 64'd0);

        // Single host, back-to-back reads
        next();
        dev_gnt = 1'b1;
        set_host(0, 1'b1, 32'h100, 1'b0, 32'h0);
        @(negedge clk);
        check("single_gnt0", 64'(host_gnt), 64'b01);
        check("single_addr0", 64'(dev_addr), 64'h100);
        check("single_we0", 64'(dev_we), 64'd0);
        check("single_be0", 64'(dev_be), 64'hF);
        sb_q.push_back('{0, 32'hA});
        next();
        set_host(0, 1'b1, 32'h104, 1'b0, 32'h0);
        @(negedge clk);
        check("single_gnt1", 64'(host_gnt), 64'b01);
        check("single_addr1", 64'(dev_addr), 64'h104);
        sb_q.push_back('{0, 32'hB});
        next();
        host_req = '0;
        dev_gnt  = 1'b0;
        respond("single_r0", 1'b0);
        respond("single_r1", 1'b0);
        @(negedge clk);
        check("single_orphan", 64'(orphan_rsp), 64'd0);

        // Round-robin with continuous requests, running into FIFO full
        next();
        do_reset();
        dev_gnt = 1'b1;
        set_host(0, 1'b1, 32'h200, 1'b1, 32'h1111_0000);
        set_host(1, 1'b1, 32'h280, 1'b0, 32'h2222_0000);
        for (int k = 0; k < 4; k++) begin
            int exp_h;
            exp_h = k % 2;
            @(negedge clk);
            check($sformatf("rr_gnt%0d", k), 64'(host_gnt), 64'(1 << exp_h));
            check($sformatf("rr_addr%0d", k), 64'(dev_addr), (exp_h == 0) ? 64'h200 : 64'h280);
            check($sformatf("rr_wdata%0d", k), 64'(dev_wdata),
                  (exp_h == 0) ? 64'h1111_0000 : 64'h2222_0000);
            sb_q.push_back('{exp_h, 32'h300 + 32'(k)});
            next();
        end
        respond("full_r0", 1'b1);
        @(negedge clk);
        check("unfull_req", 64'(dev_req), 64'd1);
        check("unfull_gnt", 64'(host_gnt), 64'b01);
        sb_q.push_back('{0, 32'h355});
        next();
        host_req = '0;
        dev_gnt  = 1'b0;
        for (int k = 0; k < 4; k++) respond($sformatf("rr_r%0d", k), 1'b0);

        // Lock holds host 1 while host 0 arrives
        do_reset();
        set_host(1, 1'b1, 32'h300, 1'b1, 32'h1234);
        @(negedge clk);
        check("lock_c1_addr", 64'(dev_addr), 64'h300);
        check("lock_c1_gnt", 64'(host_gnt), 64'd0);
        next();
        set_host(0, 1'b1, 32'h400, 1'b0, 32'h0);
        @(negedge clk);
        check("lock_c2_addr", 64'(dev_addr), 64'h300);
        next();
        @(negedge clk);
        check("lock_c3_addr", 64'(dev_addr), 64'h300);
        check("lock_c3_wdata", 64'(dev_wdata), 64'h1234);
        next();
        dev_gnt = 1'b1;
        @(negedge clk);
        check("lock_gnt1", 64'(host_gnt), 64'b10);
        check("lock_addr1", 64'(dev_addr), 64'h300);
        sb_q.push_back('{1, 32'h77});
        next();
        host_req[1] = 1'b0;
        @(negedge clk);
        check("lock_gnt0", 64'(host_gnt), 64'b01);
        check("lock_addr0", 64'(dev_addr), 64'h400);
        sb_q.push_back('{0, 32'h88});
        next();
        host_req = '0;
        dev_gnt  = 1'b0;
        respond("lock_r0", 1'b0);
        respond("lock_r1", 1'b0);

        // Orphan response, then reset with tags outstanding
        dev_rvalid = 1'b1;
        dev_rdata  = 32'hBAD;
        @(negedge clk);
        check("orphan_rvalid", 64'(host_rvalid), 64'd0);
        next();
        dev_rvalid = 1'b0;
        @(negedge clk);
        check("orphan_set", 64'(orphan_rsp), 64'd1);
        next();
        dev_gnt = 1'b1;
        set_host(0, 1'b1, 32'h500, 1'b0, 32'h0);
        next();
        next();
        host_req = '0;
        dev_gnt  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_orphan", 64'(orphan_rsp), 64'd0);
        next();
        rst_n = 1'b1;
        dev_rvalid = 1'b1;
        @(negedge clk);
        check("post_rst_rvalid", 64'(host_rvalid), 64'd0);
        next();
        dev_rvalid = 1'b0;
        @(negedge clk);
        check("post_rst_orphan", 64'(orphan_rsp), 64'd1);

        // Stall counter over 5 blocked cycles
        next();
        do_reset();
        set_host(0, 1'b1, 32'h600, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) next();
        @(negedge clk);
`ifdef IBEX_MEM_ARB_PERF_EN
        check("stall_cnt", 64'(arb_stall_cnt), 64'd5);
`else
        check("stall_cnt", 64'(arb_stall_cnt), 64'd0);
`endif
        next();
        dev_gnt = 1'b1;
        @(negedge clk);
        check("stall_gnt", 64'(host_gnt), 64'b01);
        sb_q.push_back('{0, 32'h99});
        next();
        host_req = '0;
        dev_gnt  = 1'b0;
        respond("stall_r0", 1'b0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ibex_mem_arb.md
# ibex_mem_arb

N-to-1 arbiter for the Ibex request/grant/rvalid memory protocol. It sits between several memory hosts (instruction fetch, LSU, DV stimulus agents) and a single memory device port. Hosts are arbitrated round-robin, and each accepted request is tagged in an in-order routing FIFO so that every device response is steered back to the host that issued it. Up to MAX_OUTSTANDING requests may be in flight at once.

## Interface
- NUM_HOSTS, 2: number of host ports, at least 2.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width, a multiple of 8.
- INTG_WIDTH, 7: integrity width carried with write and read data.
- MAX_OUTSTANDING, 4: routing FIFO depth, at least 1. Any value is legal, including non-powers of 2.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- host_req_i  in  NUM_HOSTS  per-host request.
- host_gnt_o  out  NUM_HOSTS  per-host grant.
- host_addr_i  in  NUM_HOSTS*ADDR_WIDTH  packed; host i occupies slice i.
- host_we_i  in  NUM_HOSTS  write enable.
- host_be_i  in  NUM_HOSTS*DATA_WIDTH/8  byte enables.
- host_wdata_i  in  NUM_HOSTS*DATA_WIDTH  write data.
- host_wintg_i  in  NUM_HOSTS*INTG_WIDTH  write integrity.
- host_rvalid_o  out  NUM_HOSTS  per-host response valid.
- host_rdata_o  out  DATA_WIDTH  read data, broadcast to all hosts.
- host_rintg_o  out  INTG_WIDTH  read integrity, broadcast to all hosts.
- host_err_o  out  1  response error, broadcast to all hosts.
- dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o, dev_wintg_o  out  widths as the host fields  device request.
- dev_gnt_i  in  1  device grant.
- dev_rvalid_i, dev_rdata_i, dev_rintg_i, dev_err_i  in  widths as the host response fields  device response.
- orphan_rsp_o  out  1  sticky flag: rvalid arrived while nothing was outstanding.
- arb_stall_cnt_o  out  32  arbitration stall counter (see Configuration).

## Operation
- A handshake completes on any cycle where req and gnt are both high. A host holds req and all request fields stable until it is granted.
- Selection: round-robin starting from the host after last_grant. last_grant resets to NUM_HOSTS-1, so host 0 has first priority.
- Lock: once dev_req_o is high without dev_gnt_i, the selected host index is held in a register until the handshake. This keeps dev_* stable even if a higher-priority host raises req in the meantime.
- dev_req_o = some host_req_i high AND FIFO not full. The dev_* request fields are muxed from the selected host; when dev_req_o is low they are driven to 0.
- host_gnt_o[i] = dev_gnt_i AND dev_req_o AND selected==i. At most one bit is set per cycle.
- On a device handshake: push the selected index into the FIFO, update last_grant, and release the lock.
- On dev_rvalid_i with the FIFO non-empty: pop the head, set host_rvalid_o[head]=1, and pass rdata, rintg and err through.
- On dev_rvalid_i with the FIFO empty: assert no host_rvalid_o and set orphan_rsp_o, which stays set until reset.
- Push and pop may happen in the same cycle; the count is then unchanged.
- The full check uses the registered count only; a pop in the same cycle does not unblock a request. This keeps the path from dev_rvalid_i to dev_req_o free of combinational logic.
- Pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Zero-cycle combinational paths: host request to device request, device grant to host grant, device response to host response.
- Registered state: last_grant, lock valid and lock index, FIFO storage and pointers, count, orphan_rsp_o, stall counter.
- Reset values: FIFO empty, lock clear, orphan_rsp_o=0, arb_stall_cnt_o=0. All outputs are 0 while inputs are idle.
- Asserting rst_ni low mid-transaction discards all outstanding tags immediately. Any response arriving after reset is treated as an orphan.
- Arbitration latency: a continuously requesting host waits at most NUM_HOSTS-1 device handshakes before it is granted.

## Configuration
- IBEX_MEM_ARB_PERF_EN defined: arb_stall_cnt_o increments on every cycle where any host_req_i is high and no host_gnt_o is high. It saturates at 32'hFFFF_FFFF and resets to 0.
- IBEX_MEM_ARB_PERF_EN undefined: arb_stall_cnt_o is tied to 0 and no counter logic is instantiated.

## Test plan
- Single host, back-to-back traffic: host 0 issues reads to 0x100 and 0x104 with dev_gnt_i tied to 1, and responses return in order with rdata 0xA and 0xB. Required: host_rvalid_o = 2'b01 on both responses, carrying the matching data, and orphan_rsp_o stays 0.
- Round-robin: both hosts request continuously with dev_gnt_i tied to 1. Required: grant order is 0,1,0,1, and the FIFO holds the matching tag sequence.
- Lock: host 1 requests with dev_gnt_i low for 3 cycles, and host 0 raises req in cycle 2. Required: dev_addr_o stays at host 1's address until the grant, and host 0 is granted next.
- FIFO full: with MAX_OUTSTANDING=4, make 4 grants with no responses. Required: dev_req_o=0 on the next cycle. A response arriving in that cycle does not raise dev_req_o until the following cycle.
- Orphan and reset: a dev_rvalid_i pulse with an empty FIFO sets orphan_rsp_o=1 and asserts no host_rvalid_o. Pulling rst_ni low while 2 requests are outstanding clears the count and clears orphan_rsp_o.
- Perf counter: with IBEX_MEM_ARB_PERF_EN defined, hold dev_gnt_i low for 5 cycles with a request pending. Required: arb_stall_cnt_o=5. With the macro undefined, it stays at 0.
